// File: rtl/hilo_mul_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_mul_ctrl
//
// Requester side of the Work/Done handshake with the iterative multiplier, and
// owner of the architectural HI/LO registers.
//
//   Clk        in   clock, rising edge
//   Reset      in   asynchronous, active-high; shared with the multiplier
//   Start      in   decode issues MULT/MULTU this cycle
//   StartSign  in   1 = MULT (signed), 0 = MULTU; sampled with Start
//   OpA, OpB   in   rs / rt operands; sampled with Start
//   MtHi, MtLo in   MTHI / MTLO requests, data on WData
//   ReadHiLo   in   MFHI / MFLO in decode this cycle
//   Hi, Lo     out  architectural HI / LO (registered)
//   Busy       out  multiply in flight (RUN or DRAIN)
//   Stall      out  hold the pipeline front end (combinational)
//   MA, MB     out  multiplier operands (registered, frozen while Busy)
//   Work       out  multiplier enable (registered)
//   Sign       out  multiplier signed mode (registered, frozen while Busy)
//   Done       in   multiplier completion
//   MOut       in   multiplier product, copied bit-exact into HI:LO
// -----------------------------------------------------------------------------
module hilo_mul_ctrl #(
    parameter int NBit = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              StartSign,
    input  logic [NBit-1:0]   OpA,
    input  logic [NBit-1:0]   OpB,
    input  logic              MtHi,
    input  logic              MtLo,
    input  logic [NBit-1:0]   WData,
    input  logic              ReadHiLo,
    output logic [NBit-1:0]   Hi,
    output logic [NBit-1:0]   Lo,
    output logic              Busy,
    output logic              Stall,
    output logic [NBit-1:0]   MA,
    output logic [NBit-1:0]   MB,
    output logic              Work,
    output logic              Sign,
    input  logic              Done,
    input  logic [2*NBit-1:0] MOut
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [NBit-1:0] hi_q, hi_d;
    logic [NBit-1:0] lo_q, lo_d;
    logic [NBit-1:0] ma_q, ma_d;
    logic [NBit-1:0] mb_q, mb_d;
    logic            work_q, work_d;
    logic            sign_q, sign_d;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        work_d  = work_q;
        sign_d  = sign_q;

        case (state_q)
            ST_IDLE: begin
                work_d = 1'b0;
                if (Start) begin
                    // A launch wins over a same-cycle MT request, which is dropped.
                    ma_d    = OpA;
                    mb_d    = OpB;
                    sign_d  = StartSign;
                    work_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    if (MtHi) hi_d = WData;
                    if (MtLo) lo_d = WData;
                end
            end
            ST_RUN: begin
                // Operands and Sign stay frozen; wait for Done with no timeout.
                if (Done) begin
                    hi_d    = MOut[2*NBit-1:NBit];
                    lo_d    = MOut[NBit-1:0];
                    work_d  = 1'b0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // One Work-low cycle lets the multiplier clear Done; a Done
                // still seen here is stale and ignored.
                work_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                work_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            work_q  <= 1'b0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            work_q  <= work_d;
            sign_q  <= sign_d;
        end
    end

    assign Busy  = (state_q != ST_IDLE);
    // Requests seen while busy are not queued; the pipeline re-presents them.
    assign Stall = Busy & (Start | MtHi | MtLo | ReadHiLo);
    assign Hi    = hi_q;
    assign Lo    = lo_q;
    assign MA    = ma_q;
    assign MB    = mb_q;
    assign Work  = work_q;
    assign Sign  = sign_q;

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
module tb_hilo_mul_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start, StartSign, MtHi, MtLo, ReadHiLo;
    logic [31:0] OpA, OpB, WData;
    logic [31:0] Hi, Lo, MA, MB;
    logic        Busy, Stall, Work, Sign;
    logic        Done;
    logic [63:0] MOut;

    always #5 Clk = ~Clk;

    hilo_mul_ctrl #(.NBit(32)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartSign(StartSign),
        .OpA(OpA), .OpB(OpB), .MtHi(MtHi), .MtLo(MtLo), .WData(WData),
        .ReadHiLo(ReadHiLo), .Hi(Hi), .Lo(Lo), .Busy(Busy), .Stall(Stall),
        .MA(MA), .MB(MB), .Work(Work), .Sign(Sign), .Done(Done), .MOut(MOut)
    );

    // Iterative multiplier stand-in: 31-count delay, Done one edge later,
    // cleared as soon as Work is seen low.
    logic [5:0] mul_cnt;
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mul_cnt <= '0;
            Done    <= 1'b0;
            MOut    <= '0;
        end else if (!Work) begin
            mul_cnt <= '0;
            Done    <= 1'b0;
        end else if (mul_cnt < 6'd32) begin
            mul_cnt <= mul_cnt + 6'd1;
            if (mul_cnt == 6'd31) begin
                Done <= 1'b1;
                if (Sign) MOut <= 64'(longint'($signed(MA)) * longint'($signed(MB)));
                else      MOut <= 64'({32'd0, MA} * {32'd0, MB});
            end
        end
    end

    // Transaction-level reference: a launch occupies 34 cycles; the product
    // becomes architectural after the 33rd edge; Work is high for 33 cycles.
    int          rem;
    logic [31:0] m_hi, m_lo, m_ma, m_mb;
    logic        m_sign;
    logic [63:0] m_prod;
    int          n_assert = 0;
    int          n_fail   = 0;
    int          launches = 0;

    function automatic logic [63:0] ref_product(input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        // Two's-complement correction of the unsigned product.
        if (sg) begin
            if (a[31]) p = p - {b, 32'd0};
            if (b[31]) p = p - {a, 32'd0};
        end
        return p;
    endfunction

    task automatic model_reset();
        rem = 0; m_hi = 0; m_lo = 0; m_ma = 0; m_mb = 0; m_sign = 0; m_prod = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic st, input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input logic mh, input logic ml, input logic [31:0] wd, input logic rd);
        Start = st; StartSign = sg; OpA = a; OpB = b;
        MtHi = mh; MtLo = ml; WData = wd; ReadHiLo = rd;
        #1;
        chk("stall", {63'd0, Stall}, {63'd0, (rem != 0) && (st || mh || ml || rd)});
        chk("busy",  {63'd0, Busy},  {63'd0, rem != 0});
        chk("work",  {63'd0, Work},  {63'd0, rem > 1});
        chk("hi",    {32'd0, Hi},    {32'd0, m_hi});
        chk("lo",    {32'd0, Lo},    {32'd0, m_lo});
        chk("ma",    {32'd0, MA},    {32'd0, m_ma});
        chk("mb",    {32'd0, MB},    {32'd0, m_mb});
        chk("sign",  {63'd0, Sign},  {63'd0, m_sign});
        if (rem == 0) begin
            if (st) begin
                rem = 34; m_ma = a; m_mb = b; m_sign = sg;
                m_prod = ref_product(sg, a, b);
                launches++;
            end else begin
                if (mh) m_hi = wd;
                if (ml) m_lo = wd;
            end
        end else begin
            rem--;
            if (rem == 1) begin
                m_hi = m_prod[63:32];
                m_lo = m_prod[31:0];
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int work_cnt, busy_cnt, work_rises;
        logic work_prev;

        Reset = 1'b1;
        Start = 0; StartSign = 0; OpA = 0; OpB = 0;
        MtHi = 0; MtLo = 0; WData = 0; ReadHiLo = 0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        ReadHiLo = 1'b1;
        #1;
        chk("rst_stall", {63'd0, Stall}, 64'd0);
        chk("rst_busy",  {63'd0, Busy},  64'd0);
        chk("rst_work",  {63'd0, Work},  64'd0);
        chk("rst_hilo",  {Hi, Lo},       64'd0);
        chk("rst_mamb",  {MA, MB},       64'd0);
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        // Unsigned 3 * 5, counting Work/Busy cycles.
        cyc(1, 0, 32'h3, 32'h5, 0, 0, 0, 0);
        work_cnt = 0; busy_cnt = 1;
        for (int i = 0; i < 40; i++) begin
            if (Work) work_cnt++;
            if (Busy) busy_cnt++;
            cyc(0, 0, 0, 0, 0, 0, 0, 0);
        end
        chk("mulu_work_cycles", 64'(work_cnt), 64'd33);
        chk("mulu_busy_cycles", 64'(busy_cnt - 1), 64'd34);
        chk("mulu_hilo", {Hi, Lo}, 64'h0000_0000_0000_000F);

        // Signed -2 * 3 with a read and an MTLO hitting the busy window.
        cyc(1, 1, 32'hFFFF_FFFE, 32'h3, 0, 0, 0, 0);
        idle(5);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);
        cyc(0, 0, 0, 0, 0, 1, 32'h1234_5678, 0);
        idle(30);
        chk("mult_hilo", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFA);

        // IDLE MT writes, then Start together with MtHi.
        cyc(0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF, 0);
        chk("mt_both", {Hi, Lo}, 64'hDEAD_BEEF_DEAD_BEEF);
        cyc(1, 0, 32'h10, 32'h20, 1, 0, 32'h5555_5555, 0);
        idle(20);
        chk("start_mthi_hold", {32'd0, Hi}, 64'h0000_0000_DEAD_BEEF);
        idle(20);

        // Asynchronous reset at E10 of a multiply.
        cyc(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
        idle(9);
        Reset = 1'b1;
        #1;
        chk("abort_work", {63'd0, Work}, 64'd0);
        chk("abort_busy", {63'd0, Busy}, 64'd0);
        chk("abort_hilo", {Hi, Lo},      64'd0);
        model_reset();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        cyc(1, 1, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0);
        busy_cnt = 1;
        for (int i = 0; i < 40; i++) begin
            if (Busy) busy_cnt++;
            cyc(0, 0, 0, 0, 0, 0, 0, 0);
        end
        chk("post_abort_busy_cycles", 64'(busy_cnt - 1), 64'd34);
        chk("post_abort_hilo", {Hi, Lo}, 64'h4000_0000_0000_0000);

        // Start held high continuously.
        launches = 0; work_rises = 0; work_prev = Work;
        for (int i = 0; i < 80; i++) begin
            cyc(1, 1'($urandom_range(0, 1)), $urandom, $urandom, 0, 0, 0, 0);
            if (Work && !work_prev) work_rises++;
            work_prev = Work;
        end
        chk("held_start_launches", 64'(work_rises), 64'(launches));
        idle(40);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), $urandom, $urandom,
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), $urandom,
                ($urandom_range(0, 3) == 0));
        end
        idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
